pwm_duty_decoder: RTL and testbench

Receive-side counterpart to the team's PWM generator. The block samples an asynchronous PWM input, measures the high time and period in clock cycles, and reports the duty cycle in 10 % steps (0–10), matching the generator's increase/decrease granularity. It sits in the user-design top next to the generator, for loop-back self-test and for decoding external PWM sources. It also flags a stuck input (0 % or 100 %).

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_edge_sync.sv | 44 ++++
 rtl/pwm_duty_decoder.sv | 122 ++++++++++++
 tb/tb_pwm_duty_decoder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Constants and FSM state type shared by the PWM generator and the duty decoder.
package pwm_pkg;
  localparam int DUTY_STEPS = 10;
  localparam int DUTY_W     = 4;
  localparam int DIV_CYCLES = 4;

  typedef enum logic [0:0] {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } pwm_state_e;
endpackage

// File: rtl/pwm_edge_sync.sv
// PWM input synchronizer with registered rise/fall strobes.
// Optional 3-sample majority filter under PWM_DECODER_GLITCH_FILTER_EN.
module pwm_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync_ff;
  logic       sync_lvl;
  logic       dly;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_ff <= '0;
    else        sync_ff <= {sync_ff[0], pwm_in};

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hist <= '0;
    else        hist <= {hist[0], sync_ff[1]};

  assign sync_lvl = (sync_ff[1] & hist[0]) | (sync_ff[1] & hist[1]) | (hist[0] & hist[1]);
`else
  assign sync_lvl = sync_ff[1];
`endif

  // Strobes are registered so they line up with the delayed level.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dly  <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      dly  <= sync_lvl;
      rise <= sync_lvl & ~dly;
      fall <= ~sync_lvl & dly;
    end

  assign level = dly;
endmodule

// File: rtl/pwm_duty_decoder.sv
// Measures PWM high time and period, reports duty in tenths, flags a stuck input.
// PWM_DECODER_GLITCH_FILTER_EN adds a majority filter in pwm_edge_sync.
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_dec,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [CNT_W-1:0]  period_cnt,
  output logic              duty_valid,
  output logic              stuck
);
  localparam int              NUM_W   = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);

  logic level, rise, fall;

  pwm_edge_sync u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pwm_in (pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  pwm_state_e              state;
  logic [CNT_W-1:0]        per_ctr, hi_ctr, idle_ctr;
  logic [CNT_W-1:0]        cap_hi, cap_per;
  logic [NUM_W-1:0]        rem, dsh, num;
  logic [DUTY_W-2:0]       quo;
  logic [DIV_CYCLES-1:0]   vld_pipe;
  logic                    capture, timeout, done, step_ge;

  assign capture = ena && rise && (state == ARMED);
  assign timeout = ena && !(rise || fall) && (idle_ctr == TO_M1);
  assign done    = ena && vld_pipe[DIV_CYCLES-1] && !timeout;
  assign step_ge = (rem >= dsh);
  // Rounded numerator: 10*high + period/2
  assign num = (NUM_W'(hi_ctr) << 3) + (NUM_W'(hi_ctr) << 1) + NUM_W'(per_ctr >> 1);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      per_ctr  <= '0;
      hi_ctr   <= '0;
      idle_ctr <= '0;
      state    <= UNARMED;
    end else if (!ena) begin
      state <= UNARMED;
    end else begin
      if (rise || fall)          idle_ctr <= '0;
      else if (idle_ctr != TO_VAL) idle_ctr <= idle_ctr + 1'b1;

      if (rise) begin
        per_ctr <= CNT_W'(1);
        hi_ctr  <= {{(CNT_W-1){1'b0}}, level};
      end else begin
        if (per_ctr != CNT_MAX)           per_ctr <= per_ctr + 1'b1;
        if (level && hi_ctr != CNT_MAX)   hi_ctr  <= hi_ctr + 1'b1;
      end

      if (timeout)   state <= UNARMED;
      else if (rise) state <= ARMED;
    end

  // Restoring divide, one quotient bit per cycle, MSB first; a new capture restarts it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_pipe <= '0;
      rem      <= '0;
      dsh      <= '0;
      quo      <= '0;
      cap_hi   <= '0;
      cap_per  <= '0;
    end else if (!ena || timeout) begin
      vld_pipe <= '0;
    end else if (capture) begin
      vld_pipe <= DIV_CYCLES'(1);
      rem      <= num;
      dsh      <= NUM_W'(per_ctr) << (DIV_CYCLES - 1);
      quo      <= '0;
      cap_hi   <= hi_ctr;
      cap_per  <= per_ctr;
    end else if (|vld_pipe) begin
      vld_pipe <= {vld_pipe[DIV_CYCLES-2:0], 1'b0};
      if (step_ge) rem <= rem - dsh;
      dsh      <= dsh >> 1;
      quo      <= {quo[DUTY_W-3:0], step_ge};
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      duty_dec   <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      duty_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      if (ena && rise) stuck <= 1'b0;
      if (timeout) begin
        stuck      <= 1'b1;
        high_cnt   <= '0;
        period_cnt <= '0;
        duty_dec   <= level ? DUTY_W'(DUTY_STEPS) : '0;
        duty_valid <= 1'b1;
      end else if (done) begin
        duty_dec   <= {quo, step_ge};
        high_cnt   <= cap_hi;
        period_cnt <= cap_per;
        duty_valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized bench for pwm_duty_decoder against an event-level duty/timeout model.
module tb_pwm_duty_decoder;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
  localparam int MAXT    = 1500;
  localparam int SAT     = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ena = 1'b0;
  logic             pwm_in = 1'b0;
  logic [3:0]       duty_dec;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic             duty_valid, stuck;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .duty_dec   (duty_dec),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .duty_valid (duty_valid),
    .stuck      (stuck)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus: x[t] is the pwm_in value sampled at the t-th edge after reset release.
  bit x [0:MAXT];
  int len;
  bit e_vld [0:MAXT];
  bit e_stk [0:MAXT];
  int e_duty [0:MAXT];
  int e_hi   [0:MAXT];
  int e_per  [0:MAXT];

  task automatic push(input bit b);
    if (len < MAXT) begin
      len++;
      x[len] = b;
    end
  endtask

  task automatic add_wave(input int per, input int hi, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < per; i++) push(i < hi);
  endtask

  task automatic add_const(input bit v, input int n);
    for (int i = 0; i < n; i++) push(v);
  endtask

  function automatic int xv(input int i);
    if (i < 1 || i > len) return 0;
    return int'(x[i]);
  endfunction

  // Level the measurement logic sees at edge t (input delayed through the synchronizer).
  function automatic int lvl(input int t);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    return ((xv(t-3) + xv(t-4) + xv(t-5)) >= 2) ? 1 : 0;
`else
    return xv(t-3);
`endif
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic build_model();
    int armed = 0, prev = 0, last = 0, fired = 0, stk = 0, pend = 0;
    int p_duty = 0, p_hi = 0, p_per = 0, h, lt, lp;
    bit r, f;
    for (int t = 1; t <= len; t++) begin
      e_vld[t] = 0;
      lt = lvl(t);
      lp = lvl(t-1);
      r = (lt == 1) && (lp == 0);
      f = (lt == 0) && (lp == 1);
      if (pend == t) begin
        e_vld[t] = 1; e_duty[t] = p_duty; e_hi[t] = p_hi; e_per[t] = p_per;
        pend = 0;
      end
      if (r || f) begin
        last = t; fired = 0;
      end else if (fired == 0 && t - last == TIMEOUT) begin
        fired = 1; stk = 1; armed = 0; pend = 0;
        e_vld[t] = 1; e_duty[t] = (lt != 0) ? 10 : 0; e_hi[t] = 0; e_per[t] = 0;
      end
      if (r) begin
        stk = 0;
        if (armed != 0) begin
          p_per = imin(t - prev, SAT);
          h = 0;
          for (int i = prev; i < t; i++) h += lvl(i);
          p_hi   = imin(h, SAT);
          p_duty = (10 * p_hi + p_per / 2) / p_per;
          pend   = t + 4;
        end
        armed = 1;
        prev  = t;
      end
      e_stk[t] = stk[0];
    end
  endtask

  task automatic run_seg(input string name);
    build_model();
    ena = 1'b1;
    pwm_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_rst_duty"}, duty_dec, 0);
    chk({name, "_rst_per"}, period_cnt, 0);
    chk({name, "_rst_stuck"}, stuck, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 1; t <= len; t++) begin
      pwm_in = x[t];
      @(posedge clk);
      #1;
      chk({name, "_valid"}, duty_valid, e_vld[t]);
      chk({name, "_stuck"}, stuck, e_stk[t]);
      if (e_vld[t]) begin
        chk({name, "_duty"}, duty_dec, e_duty[t]);
        chk({name, "_high"}, high_cnt, e_hi[t]);
        chk({name, "_period"}, period_cnt, e_per[t]);
      end
      @(negedge clk);
    end
  endtask

  // Free-running 50 % wave of period 10 for the enable/reset scenario.
  int wcyc = 0;

  task automatic tick();
    @(negedge clk);
    pwm_in = ((wcyc % 10) < 5);
    wcyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int k, output bit ok);
    ok = 0;
    k = 0;
    while (!ok && k < max) begin
      tick();
      k++;
      if (duty_valid) ok = 1;
    end
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, per, hi;
    bit ok;

    len = 0; add_wave(10, 5, 8);
    run_seg("p10_d50");

    len = 0; add_wave(10, 3, 3); add_wave(10, 7, 3); add_wave(10, 4, 3); add_const(0, 20);
    run_seg("steps");

    len = 0; add_wave(7, 3, 5); add_wave(3, 1, 10); add_const(0, 20);
    run_seg("short");

    len = 0; add_const(0, 215); add_wave(10, 5, 3);
    run_seg("stuck_lo");

    len = 0; add_const(1, 215); add_wave(10, 5, 3);
    run_seg("stuck_hi");

    len = 0; add_wave(398, 199, 3); add_wave(300, 150, 2);
    run_seg("sat");

    len = 0; add_wave(10, 5, 4);
    add_const(1, 5); add_const(0, 2); add_const(1, 1); add_const(0, 2);
    add_wave(10, 5, 4);
    run_seg("glitch");

    for (int s = 0; s < 6; s++) begin
      len = 0;
      while (len < 400) begin
        if ($urandom_range(0, 7) == 0) add_const(bit'($urandom_range(0, 1)), $urandom_range(150, 260));
        else begin
          per = $urandom_range(2, 40);
          hi  = $urandom_range(1, per - 1);
          add_wave(per, hi, $urandom_range(1, 4));
        end
      end
      run_seg("rand");
    end

    // Reset mid-divide, then enable gating and re-arm.
    ena = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(60, k, ok);
    chk("ena_first_valid", ok, 1);
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_duty", duty_dec, 0);
    chk("mid_rst_high", high_cnt, 0);
    chk("mid_rst_period", period_cnt, 0);
    chk("mid_rst_valid", duty_valid, 0);
    chk("mid_rst_stuck", stuck, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(60, k, ok);
    chk("post_rst_valid", ok, 1);
    chk("post_rst_duty", duty_dec, 5);
    chk("post_rst_high", high_cnt, 5);
    chk("post_rst_period", period_cnt, 10);
    ena = 1'b0;
    repeat (20) begin
      tick();
      chk("hold_valid", duty_valid, 0);
      chk("hold_duty", duty_dec, 5);
      chk("hold_period", period_cnt, 10);
    end
    ena = 1'b1;
    wait_valid(40, k, ok);
    chk("rearm_valid", ok, 1);
    chk("rearm_late", (k >= 15), 1);
    chk("rearm_duty", duty_dec, 5);
    chk("rearm_high", high_cnt, 5);
    chk("rearm_period", period_cnt, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
